// File: rtl/fp32_pkg.sv
// Shared FP32 field constants, special encodings, the stage FSM encoding
// and the halving helper used by the per-operand front stage.
package fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int BIAS     = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // x*0.5 by exponent decrement; results that would be denormal flush to signed zero
    function automatic logic [31:0] fp32_half(input logic [31:0] a);
        logic [7:0] e;
        e = a[EXP_MSB:EXP_LSB];
        if (e == 8'hFF)
            return a;
        else if (e <= 8'd1)
            return {a[SIGN_BIT], 31'd0};
        else
            return {a[SIGN_BIT], e - 8'd1, a[MAN_MSB:0]};
    endfunction

endpackage

// File: rtl/fp32_square.sv
// FP32 squarer split over two registered steps: significand product and
// exponent/flags on the MUL step, normalise + round-to-nearest-even on NORM.
module fp32_square
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mul_en,
    input  logic        i_norm_en,
    input  logic [30:0] i_op,
    output logic [31:0] o_square
);

    logic [47:0]        r_prod;
    logic signed [9:0]  r_exp_sum;
    logic               r_nan;
    logic               r_inf;
    logic               r_zero;
    logic [31:0]        r_square;

    logic [7:0]         w_e;
    logic [47:0]        w_mant48;
    logic               w_hi;
    logic [22:0]        w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic [23:0]        w_rnd;
    logic signed [9:0]  w_exp;
    logic [31:0]        w_result;

    assign w_e      = i_op[EXP_MSB:EXP_LSB];
    assign w_mant48 = {24'd0, 1'b1, i_op[MAN_MSB:0]};

    // MUL step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prod    <= '0;
            r_exp_sum <= '0;
            r_nan     <= 1'b0;
            r_inf     <= 1'b0;
            r_zero    <= 1'b0;
        end else if (i_mul_en) begin
            r_prod    <= w_mant48 * w_mant48;
            r_exp_sum <= $signed({2'b00, w_e}) + $signed({2'b00, w_e}) - 10'sd254;
            r_nan     <= (w_e == 8'hFF) && (i_op[MAN_MSB:0] != 23'd0);
            r_inf     <= (w_e == 8'hFF) && (i_op[MAN_MSB:0] == 23'd0);
            r_zero    <= (w_e == 8'h00);
        end
    end

    // NORM step: product lies in [2^46, 2^48); bit 47 selects the one-place shift
    always_comb begin
        w_hi     = r_prod[47];
        w_frac   = w_hi ? r_prod[46:24] : r_prod[45:23];
        w_guard  = w_hi ? r_prod[23]    : r_prod[22];
        w_sticky = w_hi ? (|r_prod[22:0]) : (|r_prod[21:0]);
        w_inc    = w_guard & (w_sticky | w_frac[0]);
        w_rnd    = {1'b0, w_frac} + {23'd0, w_inc};
        w_exp    = r_exp_sum + 10'sd127 + $signed({9'd0, w_hi}) + $signed({9'd0, w_rnd[23]});

        w_result = {1'b0, w_exp[7:0], w_rnd[22:0]};
        if (r_nan)
            w_result = QNAN;
        else if (r_inf)
            w_result = PINF;
        else if (r_zero)
            w_result = 32'd0;
        else if (w_exp > 10'sd254)
            w_result = PINF;
        else if (w_exp < 10'sd1)
            w_result = 32'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_square <= '0;
        else if (i_norm_en)
            r_square <= w_result;
    end

    assign o_square = r_square;

endmodule

// File: rtl/fp_stage_one_part.sv
// Per-operand front stage: captures an FP32 operand on start and produces
// x/2, x^2 and a bit-exact copy for CORDIC, flagging completion with done.
module fp_stage_one_part
    import fp32_pkg::*;
#(
    parameter int FLT_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [FLT_DATA_WIDTH-1:0] x,
    output logic [FLT_DATA_WIDTH-1:0] half,
    output logic [FLT_DATA_WIDTH-1:0] square,
    output logic [FLT_DATA_WIDTH-1:0] x_to_cordic,
    output logic                      done
);

    state_t                    r_state;
    state_t                    w_next;
    logic [FLT_DATA_WIDTH-1:0] r_op;
    logic [FLT_DATA_WIDTH-1:0] r_cordic;
    logic [FLT_DATA_WIDTH-1:0] r_half;
    logic                      r_done;
    logic                      w_mul_en;
    logic                      w_norm_en;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_MUL;
            ST_MUL:  w_next = ST_NORM;
            ST_NORM: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // done is registered out of DONE so it lands in the following IDLE cycle,
    // where a new start can already be accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_cordic <= '0;
            r_half   <= '0;
            r_done   <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_next;
            r_done  <= (r_state == ST_DONE);
            if (r_state == ST_IDLE && start) begin
                r_op     <= x;
                r_cordic <= x;
            end
            if (r_state == ST_MUL)
                r_half <= fp32_half(r_op);
        end
    end

    assign w_mul_en  = clk_en && (r_state == ST_MUL);
    assign w_norm_en = clk_en && (r_state == ST_NORM);

    fp32_square u_square (
        .clk       (clk),
        .rst       (rst),
        .i_mul_en  (w_mul_en),
        .i_norm_en (w_norm_en),
        .i_op      (r_op[30:0]),
        .o_square  (square)
    );

    assign half        = r_half;
    assign x_to_cordic = r_cordic;
    assign done        = r_done;

endmodule

// File: tb/tb_fp_stage_one_part.sv
// Randomised self-checking bench for fp_stage_one_part against a real-arithmetic
// reference model, plus directed special values, stall, ignored-start and reset cases.
module tb_fp_stage_one_part;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [31:0] x;
    logic [31:0] half;
    logic [31:0] square;
    logic [31:0] x_to_cordic;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    fp_stage_one_part #(.FLT_DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .start       (start),
        .x           (x),
        .half        (half),
        .square      (square),
        .x_to_cordic (x_to_cordic),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_half(input logic [31:0] a);
        int e;
        e = int'(a[30:23]);
        if (e == 255) return a;
        if (e < 2) return {a[31], 31'd0};
        return a - 32'h0080_0000;
    endfunction

    // Square computed exactly in double precision, then rounded to FP32 (RNE)
    function automatic logic [31:0] ref_square(input logic [31:0] a);
        int          e;
        int          de;
        int          be;
        real         v;
        real         p;
        logic [63:0] b;
        logic [22:0] fr;
        logic [28:0] rest;
        e = int'(a[30:23]);
        if (e == 255) return (a[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (e == 0) return 32'd0;
        v    = $bitstoreal({1'b0, 11'(e - 127 + 1023), a[22:0], 29'd0});
        p    = v * v;
        b    = $realtobits(p);
        de   = int'(b[62:52]) - 1023;
        fr   = b[51:29];
        rest = b[28:0];
        if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && fr[0])) begin
            if (fr == 23'h7F_FFFF) begin
                fr = 23'd0;
                de++;
            end else begin
                fr++;
            end
        end
        be = de + 127;
        if (be > 254) return 32'h7F80_0000;
        if (be < 1) return 32'd0;
        return {1'b0, 8'(be), fr};
    endfunction

    // One operand through the stage; optional clk_en stall starting at cycle
    // stall_at, optional extra start poked during MUL, optional done-hold check.
    task automatic run_op(input logic [31:0] v, input int stall_at, input int stall_len,
                          input bit poke, input bit hold_done);
        int c;
        int extra;
        @(negedge clk);
        start = 1'b1;
        x     = v;
        @(negedge clk);
        start = 1'b0;
        c     = 0;
        if (poke) begin
            start = 1'b1;
            x     = $urandom;
        end
        while (c < 40 && !done) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (c == 1)
                chk("cordic_early", x_to_cordic, v);
            if (!done)
                clk_en = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
        end
        clk_en = 1'b1;
        chk("latency", 32'(c), 32'(3 + stall_len));
        chk("half", half, ref_half(v));
        chk("square", square, ref_square(v));
        chk("cordic", x_to_cordic, v);
        if (hold_done) begin
            clk_en = 1'b0;
            repeat (3) @(negedge clk);
            chk("done_hold", 32'(done), 32'd1);
            clk_en = 1'b1;
        end
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        if (poke) begin
            extra = 0;
            repeat (8) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("poke_ignored", 32'(extra), 32'd0);
        end
    endtask

    task automatic reset_midop(input logic [31:0] v);
        int seen;
        @(negedge clk);
        start = 1'b1;
        x     = v;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_half", half, 32'd0);
        chk("rst_square", square, 32'd0);
        chk("rst_cordic", x_to_cordic, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("rst_no_done", 32'(seen), 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[30:23] = 8'hFF;
            1: r[30:23] = 8'h00;
            2: r[30:23] = 8'(1 + $urandom_range(0, 1));
            3: r[30:23] = 8'(190 + $urandom_range(0, 10));
            4: r[30:23] = 8'(60 + $urandom_range(0, 8));
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] dir [8];
        rst    = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        x      = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_half", half, 32'd0);
        chk("reset_square", square, 32'd0);
        chk("reset_cordic", x_to_cordic, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b1;

        run_op(32'h4040_0000, 0, 0, 1'b0, 1'b0);
        chk("three_half", half, 32'h3FC0_0000);
        chk("three_square", square, 32'h4110_0000);

        dir = '{32'hC000_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h0080_0000,
                32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001, 32'h3FB5_04F3};
        foreach (dir[i])
            run_op(dir[i], 0, 0, 1'b0, 1'b0);

        run_op(32'h4040_0000, 1, 5, 1'b1, 1'b0);
        run_op(32'hC0A0_0000, 2, 3, 1'b0, 1'b1);

        reset_midop(32'h4120_0000);
        run_op(32'h4040_0000, 0, 0, 1'b0, 1'b0);

        repeat (40)
            run_op(rand_operand(), 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
